// File: rtl/rc4_pkg.sv
// Shared RC4 lab types: S-array arbiter states, requester ids.
// Imported by the S-RAM arbiter and its priority picker.
package rc4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int REQ_INIT    = 0;
  localparam int REQ_KSA     = 1;
  localparam int REQ_PRGA    = 2;
  localparam int OWNER_W     = 2;
  localparam int NUM_REQ_DEF = 3;

  // One-hot decode of an owner index (up to four requesters).
  function automatic logic [3:0] owner_onehot(
    input logic [OWNER_W-1:0] idx
  );
    owner_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/s_mem_arbiter_pick.sv
// arb_pick: combinational winner picker for the S-RAM arbiter.
// S_ARB_RR_EN selects round-robin from i_ptr; otherwise index 0 wins.
module arb_pick
  import rc4_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWNER_W-1:0] i_ptr,
  output logic [OWNER_W-1:0] o_winner,
  output logic               o_found
);

`ifdef S_ARB_RR_EN
  // Scan from the pointer upwards, wrapping; the nearest request wins.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(i_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[idx]) begin
        o_found  = 1'b1;
        o_winner = OWNER_W'(idx);
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = |i_ptr;

  // Fixed priority: scan downwards so the lowest index is taken last.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_found  = 1'b1;
        o_winner = OWNER_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: shares the single-port S RAM among init/KSA/PRGA.
// Define S_ARB_RR_EN for round-robin priority (default fixed).
module s_mem_arbiter
  import rc4_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wren,
  input  logic [NUM_REQ*ADDR_W-1:0] address,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [OWNER_W-1:0]        owner,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q
);

  arb_state_t           r_state;
  arb_state_t           w_next;
  logic [OWNER_W-1:0]   r_owner;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_rvalid;
  logic [OWNER_W-1:0]   w_ptr;
  logic [OWNER_W-1:0]   w_win;
  logic                 w_found;
  logic [3:0]           w_win_oh;
  logic [3:0]           w_own_oh;
  logic                 w_req_own;
  logic                 w_wren_own;
  logic [ADDR_W-1:0]    w_addr_own;
  logic [DATA_W-1:0]    w_data_own;
  logic                 w_access;
  logic                 w_take;

  arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (w_ptr),
    .o_winner (w_win),
    .o_found  (w_found)
  );

  assign w_win_oh = owner_onehot(w_win);
  assign w_own_oh = owner_onehot(r_owner);

  // Select the current owner's request bundle.
  always_comb begin
    w_req_own  = 1'b0;
    w_wren_own = 1'b0;
    w_addr_own = '0;
    w_data_own = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OWNER_W'(i)) begin
        w_req_own  = req[i];
        w_wren_own = wren[i];
        w_addr_own = address[i*ADDR_W +: ADDR_W];
        w_data_own = data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_access = (r_state == GRANT) && w_req_own;
  assign w_take   = (w_next == GRANT) && (r_state != GRANT);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; DRAIN re-arbitrates without passing through IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_found ? GRANT : IDLE;
      GRANT:   w_next = w_req_own ? GRANT : DRAIN;
      DRAIN:   w_next = w_found ? GRANT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // RAM port mux: owner drives the RAM only while it still requests.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (w_access) begin
      mem_address = w_addr_own;
      mem_data    = w_data_own;
      mem_wren    = w_wren_own;
    end
  end

  // Owner and grant latch on entry to GRANT; grant clears on exit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner <= '0;
      r_gnt   <= '0;
    end else if (w_take) begin
      r_owner <= w_win;
      r_gnt   <= w_win_oh[NUM_REQ-1:0];
    end else if (w_next != GRANT) begin
      r_gnt   <= '0;
    end
  end

  // Read-valid follows each granted read by one cycle (RAM latency).
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_rvalid <= '0;
    else if (w_access && !w_wren_own)
      r_rvalid <= w_own_oh[NUM_REQ-1:0];
    else
      r_rvalid <= '0;
  end

`ifdef S_ARB_RR_EN
  logic [OWNER_W-1:0] r_ptr;

  // Round-robin pointer moves past each new winner.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ptr <= '0;
    else if (w_take)
      r_ptr <= (w_win == OWNER_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = mem_q;
  assign busy   = (r_state != IDLE);
  assign owner  = r_owner;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: directed scoreboard bench for s_mem_arbiter.
// Expected reads are queued at issue; a negedge monitor checks rvalid.
module tb_s_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  wren;
  logic [23:0] address;
  logic [23:0] data;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;
  logic [1:0]  owner;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;

  logic [7:0]  ram [256];

  typedef struct {
    int id;
    int d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  s_mem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .wren        (wren),
    .address     (address),
    .data        (data),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .busy        (busy),
    .owner       (owner),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int d);
    exp_t e;
    e.id = id;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic set_a(input int i, input int a);
    address[i*8 +: 8] = 8'(a);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    wren    = '0;
    address = '0;
    data    = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: each rvalid pulse must match the queue head.
  always @(negedge clk) begin
    if (rvalid != 3'b000) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexp: got %b want none at %0t",
                 rvalid, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid_id", int'(rvalid), 1 << e.id);
        chk("rdata", int'(rdata), e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[8'h20] = 8'h5C;
    do_reset();

    // Reset state
    reset_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rvalid", int'(rvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_mem_wren", int'(mem_wren), 0);
    reset_n = 1'b1;

    // Single read burst, requester 1
    step();
    req[1] = 1'b1;
    set_a(1, 0);
    @(negedge clk);
    chk("t1_gnt_N", int'(gnt), 0);
    step();
    for (int a = 0; a < 4; a++) begin
      set_a(1, a);
      push(1, a);
      @(negedge clk);
      chk("t1_gnt", int'(gnt), 3'b010);
      chk("t1_maddr", int'(mem_address), a);
      step();
    end
    req[1] = 1'b0;
    @(negedge clk);
    chk("t1_rel_addr", int'(mem_address), 0);
    step();
    @(negedge clk);
    chk("t1_drain_busy", int'(busy), 1);
    chk("t1_drain_gnt", int'(gnt), 0);
    step();
    @(negedge clk);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_owner", int'(owner), 1);

    // Write then read, requester 0
    do_reset();
    req[0]  = 1'b1;
    wren[0] = 1'b1;
    set_a(0, 8'h10);
    data[7:0] = 8'hA5;
    step();
    @(negedge clk);
    chk("t2_gnt", int'(gnt), 3'b001);
    chk("t2_wren", int'(mem_wren), 1);
    step();
    wren[0] = 1'b0;
    push(0, 8'hA5);
    step();
    req[0] = 1'b0;
    step();
    step();

    // Contention: req0 and req2 together
    do_reset();
    req = 3'b101;
    set_a(0, 1);
    set_a(2, 2);
    step();
    @(negedge clk);
    chk("t3_gnt0", int'(gnt), 3'b001);
    push(0, 1);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t3_K_wren", int'(mem_wren), 0);
    step();
    @(negedge clk);
    chk("t3_drain_gnt", int'(gnt), 0);
    chk("t3_drain_busy", int'(busy), 1);
    step();
    @(negedge clk);
    chk("t3_gnt2", int'(gnt), 3'b100);
    chk("t3_owner2", int'(owner), 2);
    push(2, 2);
    step();
    req[2] = 1'b0;
    step();
    step();

`ifdef S_ARB_RR_EN
    // Round-robin: all held, each releases after two granted cycles
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 3; i++) set_a(i, i);
    for (int n = 0; n < 4; n++) begin
      int w;
      w = (n == 3) ? 0 : n;
      step();
      @(negedge clk);
      chk("rr_gnt", int'(gnt), 1 << w);
      push(w, w);
      step();
      push(w, w);
      step();
      req[w] = 1'b0;
      step();
      if (n == 3) req = '0;
      else        req[w] = 1'b1;
      @(negedge clk);
      chk("rr_drain_gnt", int'(gnt), 0);
    end
    step();
    step();
`endif

    // Release with a read in flight
    do_reset();
    req[1] = 1'b1;
    set_a(1, 8'h20);
    step();
    @(negedge clk);
    chk("t5_gnt", int'(gnt), 3'b010);
    push(1, 8'h5C);
    step();
    req[1]  = 1'b0;
    wren[1] = 1'b1;
    data[15:8] = 8'hFF;
    @(negedge clk);
    chk("t5_K_wren", int'(mem_wren), 0);
    chk("t5_K_addr", int'(mem_address), 0);
    step();
    @(negedge clk);
    chk("t5_drain_wren", int'(mem_wren), 0);
    chk("t5_drain_busy", int'(busy), 1);
    wren[1] = 1'b0;
    step();
    @(negedge clk);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_ram_kept", int'(ram[8'h20]), 8'h5C);

    // Reset mid-burst with a read in flight
    do_reset();
    req[1] = 1'b1;
    set_a(1, 3);
    step();
    @(negedge clk);
    chk("t6_gnt", int'(gnt), 3'b010);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_gnt", int'(gnt), 0);
    chk("t6_rst_rvalid", int'(rvalid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    step();
    @(negedge clk);
    chk("t6_regnt", int'(gnt), 3'b010);
    push(1, 3);
    step();
    req[1] = 1'b0;
    step();
    step();
    step();

    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
